// File: rtl/udp_csum_clear.sv
// udp_csum_clear: zeroes the UDP checksum of option-less IPv4/UDP packets ahead of the
// crypto stage so a stale checksum does not survive encryption; stats and bypass on the ring.

`ifndef UDP_CSUM_CLR_BLOCK_ADDR
`define UDP_CSUM_CLR_BLOCK_ADDR 21'h00C01
`endif

module udp_csum_clear_fifo #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             nearly_full
);
   localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS:0] DEPTH_FULL = (MAX_DEPTH_BITS+1)'(DEPTH);
   localparam logic [MAX_DEPTH_BITS:0] DEPTH_NF   = (MAX_DEPTH_BITS+1)'(DEPTH - 1);

   logic [WIDTH-1:0]          mem [DEPTH];
   logic [MAX_DEPTH_BITS-1:0] wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] rd_ptr;
   logic [MAX_DEPTH_BITS:0]   depth;
   logic                      full;
   logic                      do_wr;
   logic                      do_rd;

   assign empty       = (depth == '0);
   assign full        = (depth == DEPTH_FULL);
   assign nearly_full = (depth >= DEPTH_NF);
   assign do_rd       = rd_en && !empty;
   assign do_wr       = wr_en && (!full || do_rd);
   // Fall-through: the head entry is visible on dout whenever the FIFO is non-empty.
   assign dout        = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         depth  <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
         end
         case ({do_wr, do_rd})
            2'b10:   depth <= depth + (MAX_DEPTH_BITS+1)'(1);
            2'b01:   depth <= depth - (MAX_DEPTH_BITS+1)'(1);
            default: depth <= depth;
         endcase
      end
   end
endmodule

// state       | meaning
// MODULE_HDRS | passing module header words, waiting for data word 1
// HDR         | data words 2..6, checking ethertype/IHL/protocol, clearing at word 6
// PAYLOAD     | past the UDP header, passing through until EOP
module udp_csum_clear #(
   parameter int DATA_WIDTH        = 64,
   parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
   parameter int UDP_REG_SRC_WIDTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,

   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic [CTRL_WIDTH-1:0]        in_ctrl,
   input  logic                         in_wr,
   output logic                         in_rdy,

   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CTRL_WIDTH-1:0]        out_ctrl,
   output logic                         out_wr,
   input  logic                         out_rdy,

   input  logic                         reg_req_in,
   input  logic                         reg_ack_in,
   input  logic                         reg_rd_wr_L_in,
   input  logic [22:0]                  reg_addr_in,
   input  logic [31:0]                  reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0] reg_src_in,

   output logic                         reg_req_out,
   output logic                         reg_ack_out,
   output logic                         reg_rd_wr_L_out,
   output logic [22:0]                  reg_addr_out,
   output logic [31:0]                  reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0] reg_src_out
);
   localparam int FIFO_WIDTH = DATA_WIDTH + CTRL_WIDTH;
   localparam logic [20:0] TAG = `UDP_CSUM_CLR_BLOCK_ADDR;

   typedef enum logic [1:0] {
      MODULE_HDRS = 2'd0,
      HDR         = 2'd1,
      PAYLOAD     = 2'd2
   } state_t;

   logic [FIFO_WIDTH-1:0] fifo_dout;
   logic                  fifo_empty;
   logic                  fifo_nearly_full;
   logic [DATA_WIDTH-1:0] head_data;
   logic [CTRL_WIDTH-1:0] head_ctrl;
   logic                  xfer;

   state_t                state;
   logic [2:0]            word_cnt;
   logic                  elig;
   logic                  byp;

   logic                  is_ipv4_noopt;
   logic                  is_udp;
   logic                  clear_word;
   logic                  eop;
   logic                  pulse_seen;
   logic                  pulse_cleared;
   logic                  pulse_short;

   logic                  ctrl_bypass;
   logic [31:0]           cnt_seen;
   logic [31:0]           cnt_cleared;
   logic [31:0]           cnt_short;
   logic                  addr_hit;
   logic [31:0]           rd_val;

   udp_csum_clear_fifo #(
      .WIDTH          (FIFO_WIDTH),
      .MAX_DEPTH_BITS (2)
   ) u_in_fifo (
      .clk         (clk),
      .reset       (reset),
      .din         ({in_ctrl, in_data}),
      .wr_en       (in_wr),
      .rd_en       (xfer),
      .dout        (fifo_dout),
      .empty       (fifo_empty),
      .nearly_full (fifo_nearly_full)
   );

   assign in_rdy    = !fifo_nearly_full;
   assign head_data = fifo_dout[DATA_WIDTH-1:0];
   assign head_ctrl = fifo_dout[FIFO_WIDTH-1:DATA_WIDTH];
   assign xfer      = !fifo_empty && out_rdy;
   assign out_wr    = xfer;

   assign is_ipv4_noopt = (head_data[31:16] == 16'h0800) && (head_data[15:8] == 8'h45);
   assign is_udp        = (head_data[7:0] == 8'd17);

   // EOP ctrl 0x80 flags a word whose only valid byte is the first, so the checksum is absent.
   assign clear_word = (state == HDR) && (word_cnt == 3'd6) && elig && !byp &&
                       (head_ctrl != 8'h80);
   assign eop        = (state != MODULE_HDRS) && (head_ctrl != '0);

   assign pulse_seen    = xfer && eop;
   assign pulse_short   = pulse_seen && (word_cnt < 3'd6);
   assign pulse_cleared = xfer && clear_word;

   assign out_ctrl = head_ctrl;
   assign out_data = clear_word ? {16'h0000, head_data[47:0]} : head_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= MODULE_HDRS;
         word_cnt <= 3'd1;
         elig     <= 1'b0;
         byp      <= 1'b0;
      end else if (xfer) begin
         case (state)
            MODULE_HDRS: begin
               if (head_ctrl == '0) begin
                  word_cnt <= 3'd2;
                  byp      <= ctrl_bypass;
                  elig     <= 1'b1;
                  state    <= HDR;
               end
            end
            HDR: begin
               if (head_ctrl != '0) begin
                  state    <= MODULE_HDRS;
                  word_cnt <= 3'd1;
               end else begin
                  if (word_cnt == 3'd2) begin
                     elig <= elig & is_ipv4_noopt;
                  end
                  if (word_cnt == 3'd3) begin
                     elig <= elig & is_udp;
                  end
                  if (word_cnt == 3'd6) begin
                     state <= PAYLOAD;
                  end else begin
                     word_cnt <= word_cnt + 3'd1;
                  end
               end
            end
            PAYLOAD: begin
               if (head_ctrl != '0) begin
                  state    <= MODULE_HDRS;
                  word_cnt <= 3'd1;
               end
            end
            default: begin
               state    <= MODULE_HDRS;
               word_cnt <= 3'd1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_seen    <= '0;
         cnt_cleared <= '0;
         cnt_short   <= '0;
      end else begin
         if (pulse_seen) begin
            cnt_seen <= cnt_seen + 32'd1;
         end
         if (pulse_cleared) begin
            cnt_cleared <= cnt_cleared + 32'd1;
         end
         if (pulse_short) begin
            cnt_short <= cnt_short + 32'd1;
         end
      end
   end

   // Register map: 0 PKTS_SEEN, 1 PKTS_CLEARED, 2 PKTS_SHORT, 3 CTRL.
   assign addr_hit = reg_req_in && !reg_ack_in && (reg_addr_in[22:2] == TAG);

   always_comb begin
      rd_val = '0;
      case (reg_addr_in[1:0])
         2'd0:    rd_val = cnt_seen;
         2'd1:    rd_val = cnt_cleared;
         2'd2:    rd_val = cnt_short;
         default: rd_val = {31'b0, ctrl_bypass};
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_req_out     <= 1'b0;
         reg_ack_out     <= 1'b0;
         reg_rd_wr_L_out <= 1'b0;
         reg_addr_out    <= '0;
         reg_data_out    <= '0;
         reg_src_out     <= '0;
         ctrl_bypass     <= 1'b0;
      end else begin
         reg_req_out     <= reg_req_in;
         reg_ack_out     <= reg_ack_in | addr_hit;
         reg_rd_wr_L_out <= reg_rd_wr_L_in;
         reg_addr_out    <= reg_addr_in;
         reg_src_out     <= reg_src_in;
         reg_data_out    <= (addr_hit && reg_rd_wr_L_in) ? rd_val : reg_data_in;
         if (addr_hit && !reg_rd_wr_L_in && (reg_addr_in[1:0] == 2'd3)) begin
            ctrl_bypass <= reg_data_in[0];
         end
      end
   end
endmodule

// File: doc/udp_csum_clear.md
# udp_csum_clear

Stream stage in the user data path, placed directly upstream of the `crypto` stage. Its purpose is to keep UDP traffic valid after encryption. For IPv4 UDP packets without IP options, it zeroes the UDP checksum field before the payload is XOR-encrypted, because a stale checksum would cause receivers and middleboxes to drop the packet. All other packets, module headers and words pass through unchanged. Three event counters and one bypass control register are exposed on the register ring.

## Interface

Parameters:
- DATA_WIDTH, 64, datapath width; the block supports only 64.
- CTRL_WIDTH, DATA_WIDTH/8, control width.
- UDP_REG_SRC_WIDTH, 2, register ring source width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_data / in_ctrl / in_wr  in  64/8/1  upstream word, ctrl and write strobe.
- in_rdy  out  1  equals !nearly_full of the input FIFO.
- out_data / out_ctrl / out_wr  out  64/8/1  word, ctrl and write strobe to `crypto`.
- out_rdy  in  1  downstream ready.
- reg_req/ack/rd_wr_L/addr/data/src _in  in  ring widths  register ring input.
- Same signals _out  out  ring widths  register ring output.

## Operation

**Input buffering**
- Input goes into a fallthrough_small_fifo, WIDTH 72, MAX_DEPTH_BITS 2.
- A word transfers on a cycle with FIFO non-empty and out_rdy = 1. On that cycle out_wr = 1 and rd_en = 1.
- out_data and out_ctrl are the FIFO head, except for the modified field below.

**Registers (generic_regs)**
- TAG = `UDP_CSUM_CLR_BLOCK_ADDR.
- One software register, CTRL. Bit0 = bypass. It resets to 0, so the block is enabled after reset.
- Three counters:
  - PKTS_SEEN: packets that reached EOP.
  - PKTS_CLEARED: packets whose checksum was zeroed.
  - PKTS_SHORT: packets that hit EOP before data word 6.
- Counter updates are one-cycle pulses on the transfer cycle that causes them.

**States**
- MODULE_HDRS
  - Transfers pass through.
  - On transfer of a word with ctrl == 0: set word_cnt = 2, latch byp = CTRL[0], set elig = 1, go to HDR.
- HDR (data words 2..6)
  - On each transfer, word_cnt increments.
  - Word 2: elig &= (data[31:16] == 16'h0800) && (data[15:8] == 8'h45).
  - Word 3: elig &= (data[7:0] == 8'd17).
  - Word 6, when elig && !byp && ctrl != 8'h80: drive out_data[63:48] = 0, keep out_data[47:0] as received, and pulse PKTS_CLEARED.
  - Word 6 with ctrl == 0: go to PAYLOAD.
- PAYLOAD
  - Pass through until EOP.
- EOP handling (any state except MODULE_HDRS)
  - A transfer with ctrl != 0 pulses PKTS_SEEN and returns to MODULE_HDRS.
  - If word_cnt < 6 at EOP, also pulse PKTS_SHORT; no modification occurs.
- Word numbering: word 1 is the first data word (dst MAC). Module header words are not counted.
- Bypass is sampled once per packet, at word 1. A CTRL write mid-packet affects only the next packet.

## Timing

- Latency: a word written on cycle N may appear on out_* at cycle N+1, given out_rdy. The output is combinational from the FIFO head and has no added pipeline.
- Throughput: one word per cycle while out_rdy stays high.
- out_rdy low: out_wr = 0, nothing is dequeued and state holds. The head word stays on out_data with its modification applied.
- FIFO empty: out_wr = 0 and state holds.
- in_rdy deasserts when the FIFO is nearly full (3 of 4 entries). Upstream may still write one more word.
- Reset:
  - Outputs: out_wr = 0; the FIFO is flushed.
  - Internal: state = MODULE_HDRS, word_cnt = 1, elig = 0, byp = 0.
  - Registers: generic_regs resets its counters to 0 and CTRL to 0.
  - Reset mid-packet discards the partial packet. The next word accepted is treated as a module header.
- word_cnt is 3 bits and does not advance past 6. It cannot wrap.

## Test plan

- IPv4 UDP packet, ethertype 0x0800, ver/IHL 0x45, proto 17, 8 data words, word 6 = 64'h1234_5678_9ABC_DEF0 → out word 6 = 64'h0000_5678_9ABC_DEF0. All other words bit-identical. PKTS_SEEN = 1, PKTS_CLEARED = 1.
- Same packet as TCP (proto 6), then as IHL 0x46 → both pass unchanged. PKTS_CLEARED stays 0 and PKTS_SEEN = 2.
- Write CTRL = 1, then send a UDP packet → unmodified. Write CTRL = 0 between words 3 and 4 of a second UDP packet → that packet is still unmodified; the third UDP packet is cleared.
- 5-data-word packet with EOP at word 5 → passes unchanged, PKTS_SHORT = 1. A UDP packet whose word 6 is EOP with ctrl 8'h80 → unmodified; with ctrl 8'h40 → [63:48] zeroed.
- Random out_rdy (50%) with back-to-back UDP packets and 2 module header words each → the output stream equals the expected stream. Data is never lost or duplicated, and the FIFO never overflows while in_wr obeys in_rdy.
- Assert reset during word 4 of a UDP packet → out_wr = 0 the next cycle. The following packet is processed correctly from its module headers.
